// File: rtl/ysyx_22050710_redirect_ctrl.sv
// Fetch redirect controller: owns the fetch PC, keeps at most one fetch in flight,
// and steers wrong-path responses to discard after branch or trap redirects.
module ysyx_22050710_redirect_ctrl #(
  parameter int               PC_WD    = 64,
  parameter logic [PC_WD-1:0] RESET_PC = PC_WD'(64'h0000_0000_8000_0000)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_br_valid,
  input  logic             i_br_taken,
  input  logic [PC_WD-1:0] i_br_target,
  input  logic             i_id_stall,
  input  logic             i_trap_valid,
  input  logic [PC_WD-1:0] i_trap_target,
  input  logic             i_ifid_ready,
  output logic             o_fetch_req,
  output logic [PC_WD-1:0] o_fetch_pc,
  input  logic             i_fetch_ready,
  input  logic             i_fetch_rvalid,
  output logic             o_inst_valid,
  output logic             o_fetch_discard,
  output logic             o_flush,
  output logic [31:0]      o_redirect_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [PC_WD-1:0] pc_q;
  logic [PC_WD-1:0] pc_nxt;
  logic [PC_WD-1:0] tgt;
  logic             redir;
  logic             accept;
  logic             inst_valid;
  logic             discard;
  logic [31:0]      redirect_cnt;

  // Redirect request and halfword-aligned target; trap beats branch.
  always_comb begin
    redir = i_trap_valid | (i_br_valid & i_br_taken & ~i_id_stall);
    if (i_trap_valid) begin
      tgt = i_trap_target & ~PC_WD'(1);
    end else begin
      tgt = i_br_target & ~PC_WD'(1);
    end
  end

  // Request is not gated by redir: a fetch issued alongside a redirect is tracked as wrong-path.
  always_comb begin
    o_fetch_req = (state == S_IDLE) & i_ifid_ready & ~i_rst;
    accept      = o_fetch_req & i_fetch_ready;
  end

  // Next-state and response classification.
  always_comb begin
    state_nxt  = state;
    inst_valid = 1'b0;
    discard    = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt = redir ? S_DROP : S_WAIT;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        if (i_fetch_rvalid) begin
          state_nxt  = S_IDLE;
          inst_valid = ~redir;
          discard    = redir;
        end else begin
          state_nxt = redir ? S_DROP : S_WAIT;
        end
      end
      S_DROP: begin
        if (i_fetch_rvalid) begin
          state_nxt = S_IDLE;
          discard   = 1'b1;
        end else begin
          state_nxt = S_DROP;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Redirect overrides the sequential increment.
  always_comb begin
    if (redir) begin
      pc_nxt = tgt;
    end else if (accept) begin
      pc_nxt = pc_q + PC_WD'(4);
    end else begin
      pc_nxt = pc_q;
    end
  end

  // Reset masks every same-cycle strobe.
  always_comb begin
    o_fetch_pc      = pc_q;
    o_inst_valid    = inst_valid & ~i_rst;
    o_fetch_discard = discard & ~i_rst;
    o_flush         = redir & ~i_rst;
    o_redirect_cnt  = redirect_cnt;
  end

  // State, PC and redirect counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= S_IDLE;
      pc_q         <= RESET_PC;
      redirect_cnt <= 32'd0;
    end else begin
      state <= state_nxt;
      pc_q  <= pc_nxt;
      if (redir) begin
        redirect_cnt <= redirect_cnt + 32'd1;
      end
    end
  end

endmodule

// File: doc/ysyx_22050710_redirect_ctrl.md
YSYX_22050710_REDIRECT_CTRL -- requirements
Module: ysyx_22050710_redirect_ctrl

Interface
REQ-001 SHALL have parameters: PC_WD, default 64, PC width; RESET_PC, default 64'h0000_0000_8000_0000, first fetch address.
REQ-002 SHALL have ports, one per line:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  reset; synchronous, active-high.
- i_br_valid  in  1  ID holds a valid branch/jump instruction whose branch-unit result is meaningful.
- i_br_taken  in  1  branch-unit taken flag.
- i_br_target  in  PC_WD  branch-unit target.
- i_id_stall  in  1  ID operands not ready; the branch result is not trusted this cycle.
- i_trap_valid  in  1  ecall/mret redirect request.
- i_trap_target  in  PC_WD  trap/return target.
- i_ifid_ready  in  1  IF/ID register can accept an instruction.
- o_fetch_req  out  1  fetch request.
- o_fetch_pc  out  PC_WD  fetch address.
- i_fetch_ready  in  1  memory accepts the request.
- i_fetch_rvalid  in  1  fetch response valid.
- o_inst_valid  out  1  the response is on-path; IF/ID captures it.
- o_fetch_discard  out  1  the response is wrong-path and is dropped.
- o_flush  out  1  kill the IF/ID register contents.
- o_redirect_cnt  out  32  count of redirects performed.

Function
REQ-003 SHALL hold pc_q (PC_WD) and a 3-state FSM: S_IDLE (no fetch outstanding), S_WAIT (one on-path fetch outstanding), S_DROP (one wrong-path fetch outstanding). At most one fetch is outstanding at any time.
REQ-004 SHALL define redir = i_trap_valid | (i_br_valid & i_br_taken & ~i_id_stall).
REQ-005 SHALL select the target with trap priority: tgt = i_trap_valid ? i_trap_target : i_br_target. Bit 0 of tgt is forced to 0 before use.
REQ-006 SHALL drive o_flush = redir combinationally, in the same cycle. When i_br_valid=1 and i_id_stall=1, branch input SHALL be ignored.
REQ-007 SHALL drive o_fetch_req = (state==S_IDLE) & i_ifid_ready & ~i_rst, with o_fetch_pc = pc_q. o_fetch_req SHALL NOT be gated by redir.
REQ-008 A fetch is accepted when o_fetch_req & i_fetch_ready. Without redir, acceptance SHALL set state to S_WAIT and pc_q to pc_q+4, modulo 2^PC_WD (wraps).
REQ-009 In S_WAIT with i_fetch_rvalid and no redir, SHALL assert o_inst_valid=1 and return to S_IDLE in the next cycle.
REQ-010 In S_DROP with i_fetch_rvalid, SHALL assert o_fetch_discard=1 and o_inst_valid=0, then return to S_IDLE.
REQ-011 On redir, SHALL load pc_q <= tgt, overriding REQ-008 increment, and set the next state as follows:
- S_IDLE with acceptance in the same cycle -> S_DROP.
- S_IDLE without acceptance -> stay S_IDLE.
- S_WAIT without i_fetch_rvalid -> S_DROP.
- S_WAIT with i_fetch_rvalid -> S_IDLE, with o_inst_valid=0 and o_fetch_discard=1 that cycle.
- S_DROP -> stays S_DROP; a response arriving that cycle is discarded and the next state is S_IDLE.
REQ-012 SHALL increment o_redirect_cnt by 1 per redir cycle. The counter wraps at 2^32.
REQ-013 i_fetch_rvalid in S_IDLE SHALL be ignored: no o_inst_valid, no o_fetch_discard.
REQ-014 o_inst_valid and o_fetch_discard SHALL never be 1 in the same cycle.

Reset
REQ-015 While i_rst=1, at the clock edge SHALL set state=S_IDLE, pc_q=RESET_PC, o_redirect_cnt=0. During reset cycles o_fetch_req=0; o_inst_valid, o_fetch_discard and o_flush are forced 0.
REQ-016 Reset asserted mid-fetch (S_WAIT/S_DROP) SHALL abandon the outstanding fetch. The first request after reset deasserts SHALL use RESET_PC.

Verification
REQ-017 Reset release, i_ifid_ready=1, i_fetch_ready=1, rvalid 1 cycle after each accept -> o_fetch_pc sequence 0x80000000, 0x80000004, 0x80000008; o_inst_valid pulse per response.
REQ-018 Branch taken, target 0x80000101, in S_WAIT before rvalid -> o_flush=1 that cycle; next response has o_fetch_discard=1; next o_fetch_pc=0x80000100; o_redirect_cnt=1.
REQ-019 i_trap_valid (target 0x80001000) and taken branch (target 0x80002000) in the same cycle -> next fetch 0x80001000; counter +1 only.
REQ-020 Taken branch with i_id_stall=1 -> no o_flush, pc unchanged. Branch re-presented with i_id_stall=0 -> redirect occurs.
REQ-021 Redirect in the same cycle as acceptance at pc_q=0x80000010 -> S_DROP; that response is discarded; the following request carries the target.
REQ-022 pc_q=2^64-4 accepted -> next o_fetch_pc=0. Reset asserted in S_DROP -> next request at RESET_PC; the stale rvalid in S_IDLE is ignored.
